cdb_issue_scheduler: RTL and testbench

CDB_ISSUE_SCHEDULER -- requirements
Module: cdb_issue_scheduler

---
 rtl/cdb_issue_scheduler.sv | 168 ++++++++++++++++
 tb/tb_cdb_issue_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// cdb_issue_scheduler
//
// Purpose:
//   Arbitrates four issue queues (int, ld/st, mul, div) onto a single common
//   data bus (CDB). Every grant books the CDB for the cycle in which that
//   unit's result will appear. The bookings live in a shift-register
//   reservation table, so two results can never land on the bus together.
//   The divider is not pipelined. A counter keeps it busy for DIV_LATENCY
//   cycles after each divide issue.
//
// Parameters:
//   MUL_LATENCY  cycles from mul issue to CDB broadcast (2..15)
//   DIV_LATENCY  cycles from div issue to CDB broadcast (MUL_LATENCY+1..15)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = reset)
//   ready_int      integer issue queue has a ready entry
//   ready_ld_st    load/store issue queue has a ready entry
//   ready_mul      multiply issue queue has a ready entry
//   ready_div      divide issue queue has a ready entry
//   issue_int      grant to the integer queue this cycle
//   issue_ld_st    grant to the ld/st queue this cycle
//   issue_mul      grant to the mul queue this cycle
//   issue_div      grant to the div queue this cycle
//   cdb_sel        current CDB owner: 00 int, 01 ld_st, 10 mul, 11 div
//   cdb_sel_valid  cdb_sel is meaningful this cycle
//   div_busy       divider occupied, no new divide may issue
// ---------------------------------------------------------------------------
module cdb_issue_scheduler #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_int,
  input  logic       ready_ld_st,
  input  logic       ready_mul,
  input  logic       ready_div,
  output logic       issue_int,
  output logic       issue_ld_st,
  output logic       issue_mul,
  output logic       issue_div,
  output logic [1:0] cdb_sel,
  output logic       cdb_sel_valid,
  output logic       div_busy
);

  localparam logic [1:0] OWN_INT   = 2'b00;
  localparam logic [1:0] OWN_LD_ST = 2'b01;
  localparam logic [1:0] OWN_MUL   = 2'b10;
  localparam logic [1:0] OWN_DIV   = 2'b11;

  localparam logic [3:0] DIV_RELOAD = 4'(DIV_LATENCY - 1);

  // Reject parameter combinations the table layout cannot represent.
  if (MUL_LATENCY < 2 || MUL_LATENCY > 15 ||
      DIV_LATENCY <= MUL_LATENCY || DIV_LATENCY > 15) begin : g_bad_params
    $error("cdb_issue_scheduler: illegal MUL_LATENCY/DIV_LATENCY combination");
  end

  // Entry k describes the CDB cycle k+1 cycles after the current edge.
  logic [DIV_LATENCY-1:0]      slot_valid;
  logic [DIV_LATENCY-1:0]      slot_valid_next;
  logic [DIV_LATENCY-1:0][1:0] slot_owner;
  logic [DIV_LATENCY-1:0][1:0] slot_owner_next;

  logic       rr;
  logic [3:0] div_cnt;

  logic elig_int;
  logic elig_ld_st;
  logic elig_mul;
  logic elig_div;

  assign div_busy = (div_cnt != 4'd0);

  // A unit of latency L is eligible only if pre-shift entry L is free. That
  // entry becomes entry L-1 at the next edge, which is where the grant writes.
  // A divide always finds its slot free because nothing books further ahead.
  // While reset is low the grants are forced off so that issue_* reads 0.
  always_comb begin
    elig_div   = reset && ready_div && !div_busy;
    elig_mul   = reset && ready_mul && !slot_valid[MUL_LATENCY];
    elig_int   = reset && ready_int && !slot_valid[1];
    elig_ld_st = reset && ready_ld_st && !slot_valid[1];
  end

  // Fixed priority div > mul. The int and ld_st queues share the one-cycle
  // slot and alternate through the rr bit when both are eligible.
  always_comb begin
    issue_div   = 1'b0;
    issue_mul   = 1'b0;
    issue_int   = 1'b0;
    issue_ld_st = 1'b0;
    if (elig_div) begin
      issue_div = 1'b1;
    end else if (elig_mul) begin
      issue_mul = 1'b1;
    end else if (elig_int && elig_ld_st) begin
      issue_int   = !rr;
      issue_ld_st = rr;
    end else begin
      issue_int   = elig_int;
      issue_ld_st = elig_ld_st;
    end
  end

  // Shift the table down by one. The top entry fills empty, with owner 00,
  // so an invalid entry always carries owner 00. A grant then books its
  // landing slot. Only one grant exists per cycle, so the writes never
  // overlap.
  always_comb begin
    for (int k = 0; k < DIV_LATENCY - 1; k++) begin
      slot_valid_next[k] = slot_valid[k+1];
      slot_owner_next[k] = slot_owner[k+1];
    end
    slot_valid_next[DIV_LATENCY-1] = 1'b0;
    slot_owner_next[DIV_LATENCY-1] = 2'b00;

    if (issue_int) begin
      slot_valid_next[0] = 1'b1;
      slot_owner_next[0] = OWN_INT;
    end
    if (issue_ld_st) begin
      slot_valid_next[0] = 1'b1;
      slot_owner_next[0] = OWN_LD_ST;
    end
    if (issue_mul) begin
      slot_valid_next[MUL_LATENCY-1] = 1'b1;
      slot_owner_next[MUL_LATENCY-1] = OWN_MUL;
    end
    if (issue_div) begin
      slot_valid_next[DIV_LATENCY-1] = 1'b1;
      slot_owner_next[DIV_LATENCY-1] = OWN_DIV;
    end
  end

  // Reservation table, round-robin bit and divider occupancy counter. The
  // asynchronous reset drops every pending booking at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= '0;
      slot_owner <= '0;
      rr         <= 1'b0;
      div_cnt    <= 4'd0;
    end else begin
      slot_valid <= slot_valid_next;
      slot_owner <= slot_owner_next;
      if (issue_int) begin
        rr <= 1'b1;
      end else if (issue_ld_st) begin
        rr <= 1'b0;
      end
      if (issue_div) begin
        div_cnt <= DIV_RELOAD;
      end else if (div_cnt != 4'd0) begin
        div_cnt <= div_cnt - 4'd1;
      end
    end
  end

  // The bus owner is entry 0, which comes straight from a register.
  assign cdb_sel       = slot_owner[0];
  assign cdb_sel_valid = slot_valid[0];

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cdb_issue_scheduler
//
// Purpose:
//   Directed bench for cdb_issue_scheduler with the default latencies
//   (mul 4, div 7). Each stimulus cycle pushes its hand-computed expected
//   outputs into a queue. An independent monitor pops one entry per
//   falling edge and compares it against the DUT outputs.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_cdb_issue_scheduler;

  typedef struct {
    string      name;
    logic [3:0] issue;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       ready_int;
  logic       ready_ld_st;
  logic       ready_mul;
  logic       ready_div;
  logic       issue_int;
  logic       issue_ld_st;
  logic       issue_mul;
  logic       issue_div;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;

  exp_t exp_q[$];
  int   vec_count;
  int   err_count;

  cdb_issue_scheduler #(
    .MUL_LATENCY(4),
    .DIV_LATENCY(7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ready_int    (ready_int),
    .ready_ld_st  (ready_ld_st),
    .ready_mul    (ready_mul),
    .ready_div    (ready_div),
    .issue_int    (issue_int),
    .issue_ld_st  (issue_ld_st),
    .issue_mul    (issue_mul),
    .issue_div    (issue_div),
    .cdb_sel      (cdb_sel),
    .cdb_sel_valid(cdb_sel_valid),
    .div_busy     (div_busy)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one popped expectation against the outputs seen at this edge.
  task automatic check_output(input exp_t e);
    logic [3:0] act_issue;
    act_issue = {issue_div, issue_mul, issue_ld_st, issue_int};
    vec_count++;
    if (act_issue !== e.issue || cdb_sel !== e.sel ||
        cdb_sel_valid !== e.valid || div_busy !== e.busy) begin
      err_count++;
      $display("[TB] FAIL %s: got issue(div,mul,ldst,int)=%b sel=%b valid=%b busy=%b, expected issue=%b sel=%b valid=%b busy=%b",
               e.name, act_issue, cdb_sel, cdb_sel_valid, div_busy,
               e.issue, e.sel, e.valid, e.busy);
    end
  endtask

  // The monitor samples on the falling edge, away from the active edge, and
  // checks whatever the stimulus side has queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check_output(exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs just after a rising edge and queue the
  // expected outputs. rdy and exp_iss are ordered {div, mul, ld_st, int}.
  task automatic apply_stimulus(input string name, input logic rst_val,
                                input logic [3:0] rdy, input logic [3:0] exp_iss,
                                input logic [1:0] exp_sel, input logic exp_valid,
                                input logic exp_busy);
    exp_t e;
    reset       = rst_val;
    ready_div   = rdy[3];
    ready_mul   = rdy[2];
    ready_ld_st = rdy[1];
    ready_int   = rdy[0];
    e.name  = name;
    e.issue = exp_iss;
    e.sel   = exp_sel;
    e.valid = exp_valid;
    e.busy  = exp_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One idle cycle held in reset, which leaves the scheduler empty.
  task automatic reset_cycle(input string name);
    apply_stimulus(name, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    vec_count   = 0;
    err_count   = 0;
    reset       = 1'b0;
    ready_int   = 1'b0;
    ready_ld_st = 1'b0;
    ready_mul   = 1'b0;
    ready_div   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every queue ready: all outputs low. After release the
    // divide wins the first cycle.
    apply_stimulus("rst_all_ready0", 1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    apply_stimulus("rst_all_ready1", 1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0);
    apply_stimulus("rst_release_c0", 1'b1, 4'b1111, 4'b1000, 2'b00, 1'b0, 1'b0);
    apply_stimulus("rst_release_c1", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);

    // Round-robin between int and ld/st.
    reset_cycle("rr_reset");
    apply_stimulus("rr_c0", 1'b1, 4'b0011, 4'b0001, 2'b00, 1'b0, 1'b0);
    apply_stimulus("rr_c1", 1'b1, 4'b0011, 4'b0010, 2'b00, 1'b1, 1'b0);
    apply_stimulus("rr_c2", 1'b1, 4'b0011, 4'b0001, 2'b01, 1'b1, 1'b0);
    apply_stimulus("rr_c3", 1'b1, 4'b0011, 4'b0010, 2'b00, 1'b1, 1'b0);
    apply_stimulus("rr_c4", 1'b1, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0);
    apply_stimulus("rr_c5", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    // The mul booking blocks the int grant that would collide at c4.
    reset_cycle("mul_reset");
    apply_stimulus("mul_c0", 1'b1, 4'b0101, 4'b0100, 2'b00, 1'b0, 1'b0);
    apply_stimulus("mul_c1", 1'b1, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0);
    apply_stimulus("mul_c2", 1'b1, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0);
    apply_stimulus("mul_c3", 1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0);
    apply_stimulus("mul_c4", 1'b1, 4'b0001, 4'b0001, 2'b10, 1'b1, 1'b0);
    apply_stimulus("mul_c5", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0);
    apply_stimulus("mul_c6", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    // Divider occupancy: issues at c0 and c7, broadcasts at c7 and c14.
    reset_cycle("div_reset");
    apply_stimulus("div_c0", 1'b1, 4'b1000, 4'b1000, 2'b00, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      apply_stimulus($sformatf("div_c%0d", c), 1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b1);
    end
    apply_stimulus("div_c7", 1'b1, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
    for (int c = 8; c <= 13; c++) begin
      apply_stimulus($sformatf("div_c%0d", c), 1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b1);
    end
    apply_stimulus("div_c14", 1'b1, 4'b0000, 4'b0000, 2'b11, 1'b1, 1'b0);

    // Mul/div collision: the mul at c3 would land on the div slot at c7.
    reset_cycle("coll_reset");
    apply_stimulus("coll_c0", 1'b1, 4'b1000, 4'b1000, 2'b00, 1'b0, 1'b0);
    apply_stimulus("coll_c1", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c2", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c3", 1'b1, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c4", 1'b1, 4'b0100, 4'b0100, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c5", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c6", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
    apply_stimulus("coll_c7", 1'b1, 4'b0000, 4'b0000, 2'b11, 1'b1, 1'b0);
    apply_stimulus("coll_c8", 1'b1, 4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0);
    apply_stimulus("coll_c9", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    // Reset mid-operation drops the pending mul (c4) and div (c8) slots.
    reset_cycle("mid_reset0");
    apply_stimulus("mid_c0", 1'b1, 4'b0100, 4'b0100, 2'b00, 1'b0, 1'b0);
    apply_stimulus("mid_c1", 1'b1, 4'b1000, 4'b1000, 2'b00, 1'b0, 1'b0);
    apply_stimulus("mid_c2", 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    for (int c = 3; c <= 9; c++) begin
      apply_stimulus($sformatf("mid_c%0d", c), 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // Let the monitor drain the queue, bounded so the run always ends.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      vec_count++;
      err_count++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
